iobus_timer: RTL and testbench

IOBUS_TIMER -- requirements
Module: iobus_timer

---
 rtl/iobus_timer.sv | 152 +++++++++++++++
 tb/tb_iobus_timer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/iobus_timer.sv
// IOBUS-mapped countdown timer: CTRL/LOAD/COUNT/STATUS window with expiry interrupt.
// Define IOBUS_TIMER_PRESCALER_EN to divide the count rate by PRESCALE.
module iobus_timer #(
    parameter logic [31:0] BASE_AD  = 32'h11000080,
    parameter int          PRESCALE = 50
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        HIT,
    output logic        INTR
);

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("iobus_timer: PRESCALE must be 1..65535");
    end

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        exp_q, exp_d;
    logic        intr_q, intr_d;

    logic [31:0] off_s;
    logic [1:0]  idx_s;
    logic        wr_ctrl_s, wr_load_s, wr_stat_s;
    logic        run_s, pre_hit_s, tick_s, expire_s;

    // Byte offset into the window; anything 16 or beyond is outside it.
    assign off_s     = IOBUS_ADDR - BASE_AD;
    assign HIT       = (off_s < 32'd16);
    assign idx_s     = off_s[3:2];
    assign wr_ctrl_s = IOBUS_WR && HIT && (idx_s == 2'd0);
    assign wr_load_s = IOBUS_WR && HIT && (idx_s == 2'd1);
    assign wr_stat_s = IOBUS_WR && HIT && (idx_s == 2'd3);

    assign run_s    = ctrl_q[0] && (count_q != 32'd0);
    assign tick_s   = run_s && pre_hit_s && !wr_load_s;
    assign expire_s = tick_s && (count_q == 32'd1);

`ifdef IOBUS_TIMER_PRESCALER_EN
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] pre_q, pre_d;

    assign pre_hit_s = (pre_q == PRE_LAST);

    // Prescaler restarts whenever counting stops, EN is cleared or LOAD is written.
    always_comb begin
        pre_d = pre_q;
        if (wr_load_s || !run_s || (wr_ctrl_s && !IOBUS_OUT[0])) begin
            pre_d = 16'd0;
        end else if (pre_hit_s) begin
            pre_d = 16'd0;
        end else begin
            pre_d = pre_q + 16'd1;
        end
    end

    // Prescaler register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q <= 16'd0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign pre_hit_s = 1'b1;
`endif

    // Read mux, purely address-decoded so it also works during reset.
    always_comb begin
        RD_DATA = 32'd0;
        if (HIT) begin
            case (idx_s)
                2'd0:    RD_DATA = {29'd0, ctrl_q};
                2'd1:    RD_DATA = load_q;
                2'd2:    RD_DATA = count_q;
                2'd3:    RD_DATA = {31'd0, exp_q};
                default: RD_DATA = 32'd0;
            endcase
        end else begin
            RD_DATA = 32'd0;
        end
    end

    // Next state: expiry first, then bus writes override (LOAD beats the tick, EXP set beats clear).
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;
        intr_d  = expire_s && ctrl_q[2];

        if (expire_s) begin
            exp_d = 1'b1;
            if (ctrl_q[1]) begin
                count_d = load_q;
            end else begin
                count_d   = 32'd0;
                ctrl_d[0] = 1'b0;
            end
        end else if (tick_s) begin
            count_d = count_q - 32'd1;
        end else begin
            count_d = count_q;
        end

        if (wr_ctrl_s) begin
            ctrl_d = IOBUS_OUT[2:0];
        end else begin
            ctrl_d = ctrl_d;
        end

        if (wr_load_s) begin
            load_d  = IOBUS_OUT;
            count_d = IOBUS_OUT;
        end else begin
            load_d = load_q;
        end

        if (wr_stat_s && IOBUS_OUT[0] && !expire_s) begin
            exp_d = 1'b0;
        end else begin
            exp_d = exp_d;
        end
    end

    // State registers; reset wins over any write or tick in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_q  <= 3'd0;
            load_q  <= 32'd0;
            count_q <= 32'd0;
            exp_q   <= 1'b0;
            intr_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            exp_q   <= exp_d;
            intr_q  <= intr_d;
        end
    end

    assign INTR = intr_q;

endmodule

// File: tb/tb_iobus_timer.sv
// Scoreboard bench for iobus_timer: stimulus queues expected reads and INTR cycles,
// a negedge monitor pops and compares them.
module tb_iobus_timer;
    localparam logic [31:0] BASE = 32'h11000080;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_LOAD = BASE + 32'd4;
    localparam logic [31:0] A_CNT  = BASE + 32'd8;
    localparam logic [31:0] A_STAT = BASE + 32'd12;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] IOBUS_ADDR = 32'd0;
    logic [31:0] IOBUS_OUT = 32'd0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] RD_DATA;
    logic        HIT;
    logic        INTR;

    iobus_timer #(.BASE_AD(BASE), .PRESCALE(5)) dut (
        .CLK(CLK), .RST(RST), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .RD_DATA(RD_DATA), .HIT(HIT), .INTR(INTR)
    );

    always #10 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [31:0] exp_data_q[$];
    logic        exp_hit_q[$];
    string       name_q[$];
    int          intr_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic        rd_pend = 1'b0;

    // Monitor: compare presented reads and every INTR pulse against the scoreboard.
    always @(negedge CLK) begin : mon
        logic [31:0] ed;
        logic        eh;
        string       nm;
        int          ec;
        if (rd_pend && exp_data_q.size() > 0) begin
            ed = exp_data_q.pop_front();
            eh = exp_hit_q.pop_front();
            nm = name_q.pop_front();
            n_chk++;
            if (RD_DATA !== ed || HIT !== eh) begin
                n_fail++;
                $display("FAIL %s: got data=%h hit=%b, want data=%h hit=%b (cycle %0d)",
                         nm, RD_DATA, HIT, ed, eh, cyc);
            end
        end
        if (INTR === 1'b1) begin
            n_chk++;
            if (intr_q.size() == 0) begin
                n_fail++;
                $display("FAIL intr_unexpected: INTR=1 at cycle %0d, want no pulse", cyc);
            end else begin
                ec = intr_q.pop_front();
                if (ec != cyc) begin
                    n_fail++;
                    $display("FAIL intr_timing: pulse at cycle %0d, want cycle %0d", cyc, ec);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        step();
        IOBUS_WR   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input logic h, input string n);
        IOBUS_ADDR = a;
        exp_data_q.push_back(e);
        exp_hit_q.push_back(h);
        name_q.push_back(n);
        rd_pend = 1'b1;
        step();
        rd_pend = 1'b0;
    endtask

    int e;
    int f;

    initial begin
        step();
        step();
        rd(A_LOAD, 32'd0, 1'b1, "rst_load_during_rst");
        rd(A_CTRL, 32'd0, 1'b1, "rst_ctrl_during_rst");
        RST = 1'b0;
        rd(A_CTRL, 32'd0, 1'b1, "rst_ctrl");
        rd(A_LOAD, 32'd0, 1'b1, "rst_load");
        rd(A_CNT,  32'd0, 1'b1, "rst_count");
        rd(A_STAT, 32'd0, 1'b1, "rst_status");
        rd(BASE + 32'd16, 32'd0, 1'b0, "rst_beyond_window");
        rd(BASE - 32'd4,  32'd0, 1'b0, "rst_below_window");

        wr(A_CNT, 32'd55);
        rd(A_CNT, 32'd0, 1'b1, "count_write_ignored");
        wr(BASE + 32'd16, 32'd77);
        rd(A_LOAD, 32'd0, 1'b1, "unmapped_write_ignored");

`ifdef IOBUS_TIMER_PRESCALER_EN
        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'd5);
        e = cyc;
        intr_q.push_back(e + 10);
        rd(A_CNT, 32'd2, 1'b1, "pre_count_start");
        idle_until(e + 11);
        rd(A_CNT, 32'd0, 1'b1, "pre_count_expired");
        rd(A_STAT, 32'd1, 1'b1, "pre_status");
        wr(A_STAT, 32'd1);

        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'd5);
        e = cyc;
        idle_until(e + 6);
        wr(A_CTRL, 32'd4);
        rd(A_CNT, 32'd1, 1'b1, "pre_frozen_a");
        rd(A_CNT, 32'd1, 1'b1, "pre_frozen_b");
        wr(A_CTRL, 32'd5);
        f = cyc;
        intr_q.push_back(f + 5);
        idle_until(f + 6);
        rd(A_CNT, 32'd0, 1'b1, "pre_resume_count");
        rd(A_CTRL, 32'd4, 1'b1, "pre_resume_ctrl");
`else
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'd5);
        e = cyc;
        intr_q.push_back(e + 3);
        rd(A_CNT, 32'd3, 1'b1, "oneshot_count3");
        rd(A_CNT, 32'd2, 1'b1, "oneshot_count2");
        rd(A_CNT, 32'd1, 1'b1, "oneshot_count1");
        rd(A_CTRL, 32'd4, 1'b1, "oneshot_en_cleared");
        rd(A_CNT, 32'd0, 1'b1, "oneshot_count0");
        rd(A_STAT, 32'd1, 1'b1, "oneshot_status");
        wr(A_STAT, 32'd1);
        rd(A_STAT, 32'd0, 1'b1, "status_w1c");

        wr(A_CTRL, 32'hFFFF_FFFF);
        rd(A_CTRL, 32'd7, 1'b1, "ctrl_unused_bits");
        rd(A_CNT, 32'd0, 1'b1, "count_zero_holds");
        wr(A_CTRL, 32'd0);

        wr(A_LOAD, 32'd4);
        wr(A_CTRL, 32'd7);
        e = cyc;
        for (int k = 1; k <= 5; k++) intr_q.push_back(e + 4 * k);
        idle_until(e + 17);
        wr(A_STAT, 32'd1);
        rd(A_STAT, 32'd0, 1'b1, "auto_status_cleared");
        wr(A_STAT, 32'd1);
        rd(A_STAT, 32'd1, 1'b1, "auto_set_beats_clear");
        wr(A_CTRL, 32'd0);
        rd(A_CNT, 32'd2, 1'b1, "auto_frozen_a");
        rd(A_CNT, 32'd2, 1'b1, "auto_frozen_b");
        wr(A_STAT, 32'd1);

        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'd5);
        e = cyc;
        intr_q.push_back(e + 2);
        idle_until(e + 1);
        wr(A_CTRL, 32'd5);
        rd(A_CTRL, 32'd5, 1'b1, "ctrl_write_beats_autoclear");
        rd(A_CNT, 32'd0, 1'b1, "ctrl_expiry_count");
        rd(A_STAT, 32'd1, 1'b1, "ctrl_expiry_status");
        step();
        step();
        rd(A_CNT, 32'd0, 1'b1, "count_zero_en_no_expiry");
        wr(A_CTRL, 32'd0);
        wr(A_STAT, 32'd1);

        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'd5);
        e = cyc;
        idle_until(e + 2);
        wr(A_LOAD, 32'd9);
        rd(A_CNT, 32'd9, 1'b1, "load_beats_expiry_count");
        rd(A_LOAD, 32'd9, 1'b1, "load_beats_expiry_load");
        rd(A_STAT, 32'd0, 1'b1, "load_beats_expiry_status");
        wr(A_CTRL, 32'd0);
        rd(A_CNT, 32'd5, 1'b1, "load_then_count");

        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'd5);
        e = cyc;
        idle_until(e + 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        rd(A_CTRL, 32'd0, 1'b1, "rst_expiry_ctrl");
        rd(A_LOAD, 32'd0, 1'b1, "rst_expiry_load");
        rd(A_CNT,  32'd0, 1'b1, "rst_expiry_count");
        rd(A_STAT, 32'd0, 1'b1, "rst_expiry_status");
`endif

        step();
        step();
        n_chk++;
        if (intr_q.size() != 0) begin
            n_fail++;
            $display("FAIL intr_missing: %0d expected pulses never seen, want 0", intr_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
